// File: rtl/systolic_pe.sv
// Multiply-accumulate cell of an output-stationary systolic array.
// Operands pass straight through; the accumulator lives in the parent array.
module systolic_pe #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 11,
  parameter int PIPE   = 0,
  parameter int SAT    = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] top_i,
  input  logic [DATA_W-1:0] left_i,
  output logic [DATA_W-1:0] bottom_o,
  output logic [DATA_W-1:0] right_o,
  input  logic [ACC_W-1:0]  accum_i,
  output logic [ACC_W-1:0]  accum_o
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    mac;

  logic [DATA_W-1:0] bottom_d, bottom_q;
  logic [DATA_W-1:0] right_d, right_q;
  logic [ACC_W-1:0]  accum_d, accum_q;

  always_comb begin
    prod = {{DATA_W{1'b0}}, top_i}
         * {{DATA_W{1'b0}}, left_i};
    sum  = {1'b0, accum_i} + (ACC_W+1)'(prod);
    mac  = sum[ACC_W-1:0];
    // the extra sum bit is the carry-out that triggers saturation
    if ((SAT != 0) && sum[ACC_W]) begin
      mac = '1;
    end
    bottom_d = top_i;
    right_d  = left_i;
    accum_d  = mac;
    if (rst_i) begin
      bottom_d = '0;
      right_d  = '0;
      accum_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bottom_q <= '0;
      right_q  <= '0;
      accum_q  <= '0;
    end else begin
      bottom_q <= bottom_d;
      right_q  <= right_d;
      accum_q  <= accum_d;
    end
  end

  // unregistered cells let the array's own hop registers set the skew
  assign bottom_o = (PIPE != 0) ? bottom_q : bottom_d;
  assign right_o  = (PIPE != 0) ? right_q  : right_d;
  assign accum_o  = (PIPE != 0) ? accum_q  : accum_d;

endmodule

// File: tb/tb_systolic_pe.sv
// Scoreboard bench for systolic_pe: single cells in each mode
// plus a 4x4 output-stationary array with external hop registers.
module tb_systolic_pe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        arr_rst = 1'b0;
  logic [3:0]  top, left;
  logic [10:0] acc;

  logic [3:0]  bo0, ro0, bo1, ro1, bo2, ro2;
  logic [10:0] ao0, ao1, ao2;

  systolic_pe #(.PIPE(0), .SAT(0)) u0 (
    .clk_i(clk), .rst_i(rst), .top_i(top), .left_i(left),
    .bottom_o(bo0), .right_o(ro0), .accum_i(acc), .accum_o(ao0));

  systolic_pe #(.PIPE(0), .SAT(1)) u1 (
    .clk_i(clk), .rst_i(rst), .top_i(top), .left_i(left),
    .bottom_o(bo1), .right_o(ro1), .accum_i(acc), .accum_o(ao1));

  systolic_pe #(.PIPE(1), .SAT(0)) u2 (
    .clk_i(clk), .rst_i(rst), .top_i(top), .left_i(left),
    .bottom_o(bo2), .right_o(ro2), .accum_i(acc), .accum_o(ao2));

  // 4x4 array
  logic [3:0]  a_edge [4];
  logic [3:0]  b_edge [4];
  logic [3:0]  cl [4][4];
  logic [3:0]  ct [4][4];
  logic [3:0]  cr [4][4];
  logic [3:0]  cb [4][4];
  logic [10:0] ca [4][4];
  logic [3:0]  a_q [4][4];
  logic [3:0]  b_q [4][4];
  logic [10:0] acc_q [4][4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_r
    for (genvar gj = 0; gj < 4; gj++) begin : g_c
      if (gj == 0) begin : g_l0
        assign cl[gi][gj] = a_edge[gi];
      end else begin : g_l
        assign cl[gi][gj] = a_q[gi][gj-1];
      end
      if (gi == 0) begin : g_t0
        assign ct[gi][gj] = b_edge[gj];
      end else begin : g_t
        assign ct[gi][gj] = b_q[gi-1][gj];
      end
      systolic_pe #(.PIPE(0), .SAT(0)) u_pe (
        .clk_i(clk), .rst_i(arr_rst),
        .top_i(ct[gi][gj]), .left_i(cl[gi][gj]),
        .bottom_o(cb[gi][gj]), .right_o(cr[gi][gj]),
        .accum_i(acc_q[gi][gj]), .accum_o(ca[gi][gj]));
    end
  end

  always_ff @(posedge clk or posedge arr_rst) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (arr_rst) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end else begin
          a_q[i][j]   <= cr[i][j];
          b_q[i][j]   <= cb[i][j];
          acc_q[i][j] <= ca[i][j];
        end
      end
    end
  end

  // scoreboard
  typedef struct {
    string       nm;
    int          sel;
    int          r;
    int          c;
    logic [3:0]  eb;
    logic [3:0]  er;
    logic [10:0] ea;
  } exp_t;

  exp_t sb[$];
  logic stb = 1'b0;
  int   ntot = 0;
  int   npass = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic push(input string nm, input int sel,
                      input int eb, input int er, input int ea);
    exp_t e;
    e.nm = nm; e.sel = sel; e.r = 0; e.c = 0;
    e.eb = 4'(eb); e.er = 4'(er); e.ea = 11'(ea);
    sb.push_back(e);
  endtask

  task automatic push_arr(input string nm, input int r,
                          input int c, input int ea);
    exp_t e;
    e.nm = nm; e.sel = 3; e.r = r; e.c = c;
    e.eb = '0; e.er = '0; e.ea = 11'(ea);
    sb.push_back(e);
  endtask

  task automatic strobe();
    stb = 1'b1;
    #1;
    stb = 1'b0;
    #1;
  endtask

  exp_t        m;
  logic [3:0]  m_b, m_r;
  logic [10:0] m_a;

  always @(posedge stb) begin
    while (sb.size() > 0) begin
      m = sb.pop_front();
      m_b = '0; m_r = '0; m_a = '0;
      case (m.sel)
        0: begin m_b = bo0; m_r = ro0; m_a = ao0; end
        1: begin m_b = bo1; m_r = ro1; m_a = ao1; end
        2: begin m_b = bo2; m_r = ro2; m_a = ao2; end
        default: m_a = acc_q[m.r][m.c];
      endcase
      if (m.sel < 3) begin
        cmp({m.nm, ".bottom"}, int'(m_b), int'(m.eb));
        cmp({m.nm, ".right"}, int'(m_r), int'(m.er));
      end
      cmp({m.nm, ".accum"}, int'(m_a), int'(m.ea));
    end
  end

  // combinational vectors: top, left, accum_i, wrap result, sat result
  int vt [6] = '{3, 15, 15, 1, 0, 15};
  int vl [6] = '{5, 15, 15, 1, 9, 15};
  int va [6] = '{10, 0, 1800, 2047, 77, 2047};
  int ew [6] = '{25, 225, 2025, 0, 77, 224};
  int es [6] = '{25, 225, 2025, 2047, 77, 2047};

  logic [3:0]  am [4][4];
  logic [3:0]  bm [4][4];
  logic [10:0] em [4][4];

  task automatic run_array(input string nm);
    arr_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_edge[i] = '0;
      b_edge[i] = '0;
    end
    @(negedge clk);
    arr_rst = 1'b0;
    for (int t = 0; t < 14; t++) begin
      for (int i = 0; i < 4; i++) begin
        a_edge[i] = (t >= i && t - i < 4) ? am[i][t-i] : 4'd0;
        b_edge[i] = (t >= i && t - i < 4) ? bm[t-i][i] : 4'd0;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        push_arr($sformatf("%s[%0d][%0d]", nm, i, j), i, j,
                 int'(em[i][j]));
    strobe();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    top = '0; left = '0; acc = '0;
    rst = 1'b1;
    arr_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_edge[i] = '0;
      b_edge[i] = '0;
    end
    @(negedge clk);
    top = 4'd7; left = 4'd7; acc = 11'd5;
    #1;
    push("rst0", 0, 0, 0, 0);
    push("rst1", 1, 0, 0, 0);
    push("rst2", 2, 0, 0, 0);
    strobe();
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      top = 4'(vt[k]); left = 4'(vl[k]); acc = 11'(va[k]);
      #1;
      push($sformatf("wrap%0d", k), 0, vt[k], vl[k], ew[k]);
      push($sformatf("sat%0d", k), 1, vt[k], vl[k], es[k]);
      strobe();
    end

    // mid-operation reset
    @(negedge clk);
    top = 4'd7; left = 4'd7; acc = 11'd5;
    @(posedge clk);
    #1;
    push("pre_rst0", 0, 7, 7, 54);
    push("pre_rst2", 2, 7, 7, 54);
    strobe();
    rst = 1'b1;
    #1;
    push("mid_rst0", 0, 0, 0, 0);
    push("mid_rst1", 1, 0, 0, 0);
    push("mid_rst2", 2, 0, 0, 0);
    strobe();
    rst = 1'b0;
    #1;
    push("rel0", 0, 7, 7, 54);
    push("rel2_hold", 2, 0, 0, 0);
    strobe();
    @(posedge clk);
    #1;
    push("rel2", 2, 7, 7, 54);
    strobe();

    // registered cell: one cycle latency
    @(negedge clk);
    top = 4'd3; left = 4'd5; acc = 11'd10;
    @(posedge clk);
    #1;
    push("pipe_a", 2, 3, 5, 25);
    strobe();
    top = 4'd15; left = 4'd15; acc = 11'd1800;
    #1;
    push("pipe_hold", 2, 3, 5, 25);
    strobe();
    @(posedge clk);
    #1;
    push("pipe_b", 2, 15, 15, 2025);
    strobe();
    top = 4'd1; left = 4'd1; acc = 11'd2047;
    @(posedge clk);
    #1;
    push("pipe_wrap", 2, 1, 1, 0);
    strobe();

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        am[i][j] = 4'd2;
        bm[i][j] = 4'd3;
        em[i][j] = 11'd24;
      end
    run_array("arr_const");

    // identity times B (B = 0..15 fits the 4-bit operand)
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        am[i][j] = (i == j) ? 4'd1 : 4'd0;
        bm[i][j] = 4'(4 * i + j);
        em[i][j] = 11'(4 * i + j);
      end
    run_array("arr_ident");

    #4;
    cmp("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
